// File: rtl/sha_mem_responder.sv
// sha_mem_responder: RAM responder and run sequencer for the SHA-256 engine
module sha_mem_responder #(
  parameter int DEPTH = 256,
  parameter int OUT_WORDS = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        host_we,
  input  logic [15:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic [31:0] host_rdata,
  input  logic        run,
  input  logic [15:0] msg_addr_cfg,
  input  logic [15:0] out_addr_cfg,
  output logic        sha_start,
  output logic [15:0] sha_message_addr,
  output logic [15:0] sha_output_addr,
  input  logic        sha_done,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  output logic        busy,
  output logic        hash_valid,
  output logic [3:0]  hash_count,
  output logic        timeout_err,
  output logic        oob_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_ACK, WAIT_DONE, COMPLETE, ERROR} state_t;
  state_t state, state_nxt;
  logic [31:0] ram [DEPTH];
  logic [CW-1:0] cnt;
  logic mem_oob, host_oob, accept, waiting, tmo, in_win, oob_hit;
  logic [16:0] mem17, win_lo;
  assign mem_oob = 32'(mem_addr) >= 32'(DEPTH);
  assign host_oob = 32'(host_addr) >= 32'(DEPTH);
  assign accept = run && (state == IDLE || state == COMPLETE || state == ERROR);
  assign waiting = state == WAIT_ACK || state == WAIT_DONE;
  assign tmo = cnt == CW'(TIMEOUT_CYCLES - 1);
  assign mem17 = {1'b0, mem_addr};
  assign win_lo = {1'b0, sha_output_addr};
  assign in_win = mem17 >= win_lo && mem17 < win_lo + 17'(OUT_WORDS);
  // engine reads only count as accesses during a run; its bus may idle anywhere
  assign oob_hit = (mem_oob && (mem_we || busy)) || (host_oob && host_we && !busy);
  assign busy = state == LAUNCH || waiting;
  assign sha_start = state == LAUNCH;
  assign hash_valid = state == COMPLETE && hash_count == 4'(OUT_WORDS);
  always_comb begin
    state_nxt = accept ? LAUNCH :
                state == LAUNCH ? WAIT_ACK :
                (state == WAIT_ACK && !sha_done) ? WAIT_DONE :
                (state == WAIT_DONE && sha_done) ? COMPLETE :
                (waiting && tmo) ? ERROR : state;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk) begin
    if (host_we && !busy && !host_oob) ram[host_addr[AW-1:0]] <= host_wdata;
    if (mem_we && !mem_oob) ram[mem_addr[AW-1:0]] <= mem_write_data;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sha_message_addr <= '0;
      sha_output_addr <= '0;
      timeout_err <= 1'b0;
      oob_err <= 1'b0;
      hash_count <= '0;
      host_rdata <= '0;
      mem_read_data <= '0;
      cnt <= '0;
    end else begin
      if (accept) begin
        sha_message_addr <= msg_addr_cfg;
        sha_output_addr <= out_addr_cfg;
      end
      timeout_err <= accept ? 1'b0 : timeout_err | (waiting && state_nxt == ERROR);
      oob_err <= accept ? 1'b0 : oob_err | oob_hit;
      hash_count <= accept ? '0 :
                    (waiting && mem_we && in_win && hash_count != 4'(OUT_WORDS)) ? hash_count + 4'd1 :
                    hash_count;
      host_rdata <= host_oob ? '0 : ram[host_addr[AW-1:0]];
      mem_read_data <= mem_oob ? '0 : ram[mem_addr[AW-1:0]];
      cnt <= (state_nxt != state) ? '0 : waiting ? cnt + CW'(1) : cnt;
    end
  end
endmodule

// File: tb/tb_sha_mem_responder.sv
// tb_sha_mem_responder: directed self-checking bench for sha_mem_responder
module tb_sha_mem_responder;
  logic clk = 1'b0, reset_n = 1'b0;
  logic host_we = 1'b0, run = 1'b0, sha_done = 1'b1, mem_we = 1'b0;
  logic [15:0] host_addr = '0, msg_addr_cfg = '0, out_addr_cfg = '0, mem_addr = '0;
  logic [31:0] host_wdata = '0, mem_write_data = '0;
  logic [31:0] host_rdata, mem_read_data;
  logic sha_start, busy, hash_valid, timeout_err, oob_err;
  logic [15:0] sha_message_addr, sha_output_addr;
  logic [3:0] hash_count;
  int total = 0, bad = 0;

  sha_mem_responder dut (
    .clk(clk), .reset_n(reset_n), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .run(run),
    .msg_addr_cfg(msg_addr_cfg), .out_addr_cfg(out_addr_cfg), .sha_start(sha_start),
    .sha_message_addr(sha_message_addr), .sha_output_addr(sha_output_addr),
    .sha_done(sha_done), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data), .busy(busy),
    .hash_valid(hash_valid), .hash_count(hash_count), .timeout_err(timeout_err),
    .oob_err(oob_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    total++;
    if ({sha_start, busy, hash_valid, hash_count, timeout_err, oob_err} !== 9'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=0", {sha_start, busy, hash_valid, hash_count, timeout_err, oob_err});
    end
    total++;
    if ({host_rdata, mem_read_data, sha_message_addr, sha_output_addr} !== 96'b0) begin
      bad++;
      $display("FAIL reset_data got=%h want=0", {host_rdata, mem_read_data, sha_message_addr, sha_output_addr});
    end
    tick; tick;
    reset_n = 1'b1;
    tick;
  endtask

  task automatic test_host_rw;
    for (int i = 0; i < 20; i++) begin
      host_we = 1'b1; host_addr = 16'(i); host_wdata = 32'h0123_4675;
      tick;
    end
    host_we = 1'b0; host_addr = 16'd5;
    tick;
    total++;
    if (host_rdata !== 32'h0123_4675) begin
      bad++;
      $display("FAIL host_read5 got=%h want=01234675", host_rdata);
    end
  endtask

  task automatic test_run;
    int starts;
    starts = 0;
    msg_addr_cfg = 16'h0000; out_addr_cfg = 16'h0020; run = 1'b1;
    tick;
    run = 1'b0;
    if (sha_start === 1'b1) starts++;
    total++;
    if ({busy, sha_message_addr, sha_output_addr} !== {1'b1, 16'h0000, 16'h0020}) begin
      bad++;
      $display("FAIL run_launch busy=%b msg=%h out=%h want 1/0000/0020", busy, sha_message_addr, sha_output_addr);
    end
    tick;
    if (sha_start === 1'b1) starts++;
    sha_done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      mem_we = 1'b0;
      if (i >= 10 && i < 18) begin
        mem_we = 1'b1; mem_addr = 16'(16'h20 + i - 10); mem_write_data = 32'hA000_0000 + 32'(i);
      end
      if (i == 20) begin mem_we = 1'b1; mem_addr = 16'h28; mem_write_data = 32'h1; end
      if (i == 21) begin mem_we = 1'b1; mem_addr = 16'h1F; mem_write_data = 32'h2; end
      tick;
      if (sha_start === 1'b1) starts++;
    end
    mem_we = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL run_busy_mid got=%b want=1", busy);
    end
    sha_done = 1'b1;
    tick;
    total++;
    if (starts != 1) begin
      bad++;
      $display("FAIL start_pulses got=%0d want=1", starts);
    end
    total++;
    if ({busy, hash_valid, hash_count} !== {1'b0, 1'b1, 4'd8}) begin
      bad++;
      $display("FAIL run_complete busy=%b valid=%b count=%0d want 0/1/8", busy, hash_valid, hash_count);
    end
    host_addr = 16'h27;
    tick;
    total++;
    if (host_rdata !== 32'hA000_0011) begin
      bad++;
      $display("FAIL digest_word7 got=%h want=a0000011", host_rdata);
    end
  endtask

  task automatic test_rbw;
    mem_addr = 16'd3; mem_we = 1'b1; mem_write_data = 32'hDEAD_BEEF;
    tick;
    mem_we = 1'b0;
    total++;
    if (mem_read_data !== 32'h0123_4675) begin
      bad++;
      $display("FAIL rbw_old got=%h want=01234675", mem_read_data);
    end
    tick;
    total++;
    if (mem_read_data !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL rbw_new got=%h want=deadbeef", mem_read_data);
    end
    mem_addr = 16'd0;
  endtask

  task automatic test_timeout;
    int n;
    n = 0;
    run = 1'b1;
    tick;
    run = 1'b0;
    while (timeout_err !== 1'b1 && n < 5000) begin
      tick;
      n++;
    end
    total++;
    if (n < 4096 || n > 4098) begin
      bad++;
      $display("FAIL timeout_cycles got=%0d want=4096..4098", n);
    end
    total++;
    if ({timeout_err, busy, hash_valid} !== 3'b100) begin
      bad++;
      $display("FAIL timeout_state err=%b busy=%b valid=%b want 1/0/0", timeout_err, busy, hash_valid);
    end
  endtask

  task automatic test_oob;
    run = 1'b1;
    tick;
    run = 1'b0;
    total++;
    if ({timeout_err, busy} !== 2'b01) begin
      bad++;
      $display("FAIL rerun_clear err=%b busy=%b want 0/1", timeout_err, busy);
    end
    sha_done = 1'b0;
    tick; tick;
    host_we = 1'b1; host_addr = 16'd7; host_wdata = 32'h5555_5555;
    mem_we = 1'b1; mem_addr = 16'h01FF; mem_write_data = 32'h7777_7777;
    tick;
    host_we = 1'b0; mem_we = 1'b0;
    total++;
    if (oob_err !== 1'b1) begin
      bad++;
      $display("FAIL oob_flag got=%b want=1", oob_err);
    end
    sha_done = 1'b1;
    tick;
    total++;
    if ({busy, hash_valid, hash_count} !== {1'b0, 1'b0, 4'd0}) begin
      bad++;
      $display("FAIL oob_complete busy=%b valid=%b count=%0d want 0/0/0", busy, hash_valid, hash_count);
    end
    host_addr = 16'd7;
    tick;
    total++;
    if (host_rdata !== 32'h0123_4675) begin
      bad++;
      $display("FAIL busy_host_write got=%h want=01234675", host_rdata);
    end
    host_addr = 16'h01FF;
    tick;
    total++;
    if ({host_rdata, mem_read_data} !== 64'b0) begin
      bad++;
      $display("FAIL oob_read host=%h mem=%h want 0/0", host_rdata, mem_read_data);
    end
    mem_addr = 16'd0;
  endtask

  task automatic test_reset_mid_run;
    run = 1'b1;
    tick;
    run = 1'b0;
    total++;
    if (oob_err !== 1'b0) begin
      bad++;
      $display("FAIL oob_clear got=%b want=0", oob_err);
    end
    sha_done = 1'b0;
    tick; tick; tick;
    reset_n = 1'b0;
    #1;
    total++;
    if ({sha_start, busy, hash_valid, hash_count, timeout_err, oob_err, host_rdata, mem_read_data, sha_message_addr, sha_output_addr} !== 105'b0) begin
      bad++;
      $display("FAIL midrun_reset start=%b busy=%b count=%0d want all 0", sha_start, busy, hash_count);
    end
    @(negedge clk);
    reset_n = 1'b1;
    sha_done = 1'b1;
    host_addr = 16'd10;
    tick;
    total++;
    if ({busy, host_rdata} !== {1'b0, 32'h0123_4675}) begin
      bad++;
      $display("FAIL ram_retained busy=%b data=%h want 0/01234675", busy, host_rdata);
    end
  endtask

  initial begin
    test_reset;
    test_host_rw;
    test_run;
    test_rbw;
    test_timeout;
    test_oob;
    test_reset_mid_run;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
